pulse_width_modulation: RTL and testbench



---
 rtl/pulse_width_modulation_pkg.sv | 7 +
 rtl/pwm_period_counter.sv | 27 ++
 rtl/pulse_width_modulation.sv | 43 ++++
 tb/tb_pulse_width_modulation.sv | 127 ++++++++++++
 4 files changed

// File: rtl/pulse_width_modulation_pkg.sv
// Shared constants for the fixed-period PWM generator.
package pulse_width_modulation_pkg;

    localparam int PWM_WIDTH  = 4;
    localparam int PWM_PERIOD = 2 ** PWM_WIDTH;

endpackage

// File: rtl/pwm_period_counter.sv
// Wrapping period counter with synchronous reset and a terminal-count flag.
module pwm_period_counter
    import pulse_width_modulation_pkg::*;
#(
    parameter int WIDTH = PWM_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    output logic [WIDTH-1:0] cnt,
    output logic             tc
);

    localparam logic [WIDTH-1:0] CNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_ONE;
        end
    end

    // tc marks the last clock of the period; the duty register reloads on it.
    assign tc = (cnt == CNT_MAX);

endmodule

// File: rtl/pulse_width_modulation.sv
// Fixed-period PWM: double-buffered duty code, code 0 selects 100 % duty.
module pulse_width_modulation
    import pulse_width_modulation_pkg::*;
#(
    parameter int WIDTH = PWM_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] duty_cycle,
    output logic             out_wave
);

    logic [WIDTH-1:0] cnt;
    logic             tc;
    logic [WIDTH-1:0] duty_q;
    logic             high_next;

    pwm_period_counter #(
        .WIDTH (WIDTH)
    ) u_period_counter (
        .clk (clk),
        .rst (rst),
        .cnt (cnt),
        .tc  (tc)
    );

    assign high_next = (duty_q == '0) | (cnt < duty_q);

    // duty_q only reloads at period end so a mid-period change cannot
    // shorten or stretch the pulse currently being generated.
    always_ff @(posedge clk) begin
        if (rst) begin
            duty_q   <= duty_cycle;
            out_wave <= 1'b0;
        end else begin
            out_wave <= high_next;
            if (tc) begin
                duty_q <= duty_cycle;
            end
        end
    end

endmodule

// File: tb/tb_pulse_width_modulation.sv
// Directed bench for pulse_width_modulation: per-clock waveform and period checks.
module tb_pulse_width_modulation;
    import pulse_width_modulation_pkg::*;

    localparam int W = PWM_WIDTH;
    localparam int P = PWM_PERIOD;

    logic         clk;
    logic         rst;
    logic [W-1:0] duty_cycle;
    logic         out_wave;

    int  checks;
    int  errors;
    int  phase;
    logic prev_out;
    longint last_rise;

    pulse_width_modulation #(
        .WIDTH (W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .duty_cycle (duty_cycle),
        .out_wave   (out_wave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_bit(input string tag, input logic obs, input logic expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s t=%0t observed=%b expected=%b", tag, $time, obs, expv);
        end
    endtask

    // One clock with active duty d; phase is the counter value sampled at this edge.
    task automatic tick(input int d, input string tag);
        logic expv;
        longint now;
        @(posedge clk);
        #1;
        now  = $time - 1;
        expv = (d == 0) || (phase < d);
        check_bit(tag, out_wave, expv);
        if (out_wave === 1'b1 && prev_out === 1'b0) begin
            if (last_rise >= 0) begin
                checks++;
                assert (now - last_rise == 160) else begin
                    errors++;
                    $error("FAIL %s_period t=%0t observed=%0d expected=160", tag, $time, now - last_rise);
                end
            end
            last_rise = now;
        end
        prev_out = out_wave;
        phase    = (phase + 1) % P;
    endtask

    task automatic run(input int n, input int d, input string tag);
        for (int i = 0; i < n; i++) begin
            tick(d, tag);
        end
    endtask

    task automatic apply_reset(input string tag);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_bit(tag, out_wave, 1'b0);
        rst       = 1'b0;
        phase     = 0;
        prev_out  = 1'b0;
        last_rise = -1;
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        phase      = 0;
        prev_out   = 1'b0;
        last_rise  = -1;
        rst        = 1'b1;
        duty_cycle = W'(1);

        @(posedge clk);
        #1;
        apply_reset("reset");

        // duty 1: one high clock per 16
        run(3 * P, 1, "duty1");

        // change 1 -> 8 when cnt = 5; old duty finishes the period
        run(5, 1, "duty1_pre_change");
        duty_cycle = W'(8);
        run(P - 5, 1, "duty1_tail");
        run(2 * P, 8, "duty8");

        // 15: high 15, low 1
        duty_cycle = W'(15);
        run(P, 8, "duty8_tail");
        run(2 * P, 15, "duty15");

        // 0: always high
        duty_cycle = W'(0);
        run(P, 15, "duty15_tail");
        run(2 * P, 0, "duty0");

        // reset mid high phase with duty 8
        duty_cycle = W'(8);
        run(P, 0, "duty0_tail");
        run(3, 8, "duty8_pre_reset");
        apply_reset("mid_reset");
        run(2 * P, 8, "duty8_after_reset");

        // reset with duty 0: first edge after release is high, then stays high
        duty_cycle = W'(0);
        apply_reset("reset_duty0");
        run(P, 0, "duty0_after_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
